// File: rtl/mem_arbiter_if.sv
// Bundle of the three requester ports plus the single memory request channel.
// slave is the arbiter's view; master is the view of the requesters and memory together.
interface mem_arbiter_if #(
    parameter int ADDR_BITS = 24,
    parameter int DATA_BITS = 16
);
    logic                 ppu_req;
    logic                 cpu_req;
    logic                 ldr_req;
    logic                 ppu_we;
    logic                 cpu_we;
    logic                 ldr_we;
    logic [ADDR_BITS-1:0] ppu_addr;
    logic [ADDR_BITS-1:0] cpu_addr;
    logic [ADDR_BITS-1:0] ldr_addr;
    logic [DATA_BITS-1:0] ppu_wdata;
    logic [DATA_BITS-1:0] cpu_wdata;
    logic [DATA_BITS-1:0] ldr_wdata;
    logic                 ppu_ack;
    logic                 cpu_ack;
    logic                 ldr_ack;
    logic [DATA_BITS-1:0] rdata;

    logic                 mem_req;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic                 mem_ack;
    logic [DATA_BITS-1:0] mem_rdata;

    modport slave (
        input  ppu_req, cpu_req, ldr_req,
        input  ppu_we, cpu_we, ldr_we,
        input  ppu_addr, cpu_addr, ldr_addr,
        input  ppu_wdata, cpu_wdata, ldr_wdata,
        output ppu_ack, cpu_ack, ldr_ack, rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output ppu_req, cpu_req, ldr_req,
        output ppu_we, cpu_we, ldr_we,
        output ppu_addr, cpu_addr, ldr_addr,
        output ppu_wdata, cpu_wdata, ldr_wdata,
        input  ppu_ack, cpu_ack, ldr_ack, rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serializes PPU, CPU and loader accesses onto one memory request channel:
// fixed priority PPU > CPU > loader, with a starvation override for the loader.
module mem_arbiter #(
    parameter  int ADDR_BITS    = 24,
    parameter  int DATA_BITS    = 16,
    parameter  int STARVE_LIMIT = 8,
    localparam int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    mem_arbiter_if.slave     bus,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] dbg_starve_cnt
);

    // Handshake: a requester holds req (with we/addr/wdata) high until its ack
    // pulses for one cycle and drops req the cycle after; mem_req is held until
    // a one-cycle mem_ack, with mem_rdata valid alongside mem_ack.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ID_PPU = 2'd0,
        ID_CPU = 2'd1,
        ID_LDR = 2'd2
    } port_t;

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    state_t               state_q, state_d;
    port_t                winner_q, winner_d;
    port_t                grant_id;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 ppu_ack_q, ppu_ack_d;
    logic                 cpu_ack_q, cpu_ack_d;
    logic                 ldr_ack_q, ldr_ack_d;
    logic [CNT_W-1:0]     starve_cnt_q, starve_cnt_d;
    logic                 any_req;
    logic                 starve_hit;

    assign any_req    = bus.ppu_req | bus.cpu_req | bus.ldr_req;
    assign starve_hit = bus.ldr_req && (starve_cnt_q == LIMIT_C);

    always_comb begin
        grant_id = ID_LDR;
        if (starve_hit) begin
            grant_id = ID_LDR;
        end else if (bus.ppu_req) begin
            grant_id = ID_PPU;
        end else if (bus.cpu_req) begin
            grant_id = ID_CPU;
        end
    end

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        ppu_ack_d    = 1'b0;
        cpu_ack_d    = 1'b0;
        ldr_ack_d    = 1'b0;
        // A loader that stops asking forfeits its accumulated wait.
        starve_cnt_d = bus.ldr_req ? starve_cnt_q : '0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    winner_d  = grant_id;
                    mem_req_d = 1'b1;
                    state_d   = ST_BUSY;
                    case (grant_id)
                        ID_PPU: begin
                            mem_we_d    = bus.ppu_we;
                            mem_addr_d  = bus.ppu_addr;
                            mem_wdata_d = bus.ppu_wdata;
                        end
                        ID_CPU: begin
                            mem_we_d    = bus.cpu_we;
                            mem_addr_d  = bus.cpu_addr;
                            mem_wdata_d = bus.cpu_wdata;
                        end
                        default: begin
                            mem_we_d    = bus.ldr_we;
                            mem_addr_d  = bus.ldr_addr;
                            mem_wdata_d = bus.ldr_wdata;
                        end
                    endcase
                    if (grant_id == ID_LDR) begin
                        starve_cnt_d = '0;
                    end else if (bus.ldr_req && (starve_cnt_q != LIMIT_C)) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (bus.mem_ack) begin
                    rdata_d   = bus.mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = ST_ACK;
                    case (winner_q)
                        ID_PPU:  ppu_ack_d = 1'b1;
                        ID_CPU:  cpu_ack_d = 1'b1;
                        default: ldr_ack_d = 1'b1;
                    endcase
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            winner_q     <= ID_PPU;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
            ppu_ack_q    <= 1'b0;
            cpu_ack_q    <= 1'b0;
            ldr_ack_q    <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            ppu_ack_q    <= ppu_ack_d;
            cpu_ack_q    <= cpu_ack_d;
            ldr_ack_q    <= ldr_ack_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.rdata      = rdata_q;
    assign bus.ppu_ack    = ppu_ack_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.ldr_ack    = ldr_ack_q;
    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requester and memory models, a scoreboard of expected
// completions, directed scenarios followed by a short randomized run.
module tb_mem_arbiter;

    localparam int AW    = 24;
    localparam int DW    = 16;
    localparam int LIM   = 8;
    localparam int CW    = 4;
    localparam int EXP_W = 2 + 1 + AW + DW + DW;

    typedef struct packed {
        logic [1:0]    id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    typedef struct packed {
        logic [1:0]    id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [7:0]    rep;
    } cmd_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]    dbg_state;
    logic [CW-1:0] dbg_starve_cnt;

    mem_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

    mem_arbiter #(
        .ADDR_BITS(AW),
        .DATA_BITS(DW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .dbg_state(dbg_state),
        .dbg_starve_cnt(dbg_starve_cnt)
    );

    // ---------------- shared bench state ----------------
    int n_checks = 0;
    int n_err    = 0;

    logic [EXP_W-1:0] exp_q[$];
    cmd_t             cmd_q[$];
    acc_t             mem_log_q[$];
    int               ack_id_q[$];
    int               ack_cyc_q[$];

    int            mem_lat          = 1;
    bit            mem_auto         = 1'b1;
    bit            stray_ack        = 1'b0;
    int            last_mem_ack_cyc = 0;
    int            max_starve       = 0;
    int            starve_at_ldr    = -1;
    logic [DW-1:0] last_rdata       = '0;

    logic [2:0]    req_v;
    logic [2:0]    we_v;
    logic [2:0]    reissue_v;
    logic [AW-1:0] addr_v[3];
    logic [DW-1:0] wdata_v[3];
    logic [2:0]    ack_v;

    assign bus.ppu_req   = req_v[0];
    assign bus.cpu_req   = req_v[1];
    assign bus.ldr_req   = req_v[2];
    assign bus.ppu_we    = we_v[0];
    assign bus.cpu_we    = we_v[1];
    assign bus.ldr_we    = we_v[2];
    assign bus.ppu_addr  = addr_v[0];
    assign bus.cpu_addr  = addr_v[1];
    assign bus.ldr_addr  = addr_v[2];
    assign bus.ppu_wdata = wdata_v[0];
    assign bus.cpu_wdata = wdata_v[1];
    assign bus.ldr_wdata = wdata_v[2];
    assign ack_v         = {bus.ldr_ack, bus.cpu_ack, bus.ppu_ack};

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 24'h004000) return 16'hBEEF;
        return a[15:0] ^ 16'h5A3C;
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_cmd(input int id, input bit we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input int rep);
        cmd_t c;
        c.id    = 2'(id);
        c.we    = we;
        c.addr  = addr;
        c.wdata = wdata;
        c.rep   = 8'(rep);
        cmd_q.push_back(c);
    endtask

    task automatic raise(input int i);
        exp_t e;
        req_v[i] = 1'b1;
        e.id     = 2'(i);
        e.we     = we_v[i];
        e.addr   = addr_v[i];
        e.wdata  = wdata_v[i];
        e.rdata  = mem_fn(addr_v[i]);
        exp_q.push_back(e);
    endtask

    task automatic clear_logs();
        ack_id_q.delete();
        ack_cyc_q.delete();
    endtask

    task automatic drain(input int budget);
        int n;
        bit done;
        n = 0;
        done = (exp_q.size() == 0) && (cmd_q.size() == 0) && (req_v == 0) && (reissue_v == 0);
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (exp_q.size() == 0) && (cmd_q.size() == 0) && (req_v == 0) && (reissue_v == 0);
        end
        check("drain_timeout", 64'(!done), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- requester model ----------------
    initial begin : requester
        logic [7:0] rep[3];
        cmd_t c;
        req_v     = '0;
        we_v      = '0;
        reissue_v = '0;
        for (int i = 0; i < 3; i++) begin
            addr_v[i]  = '0;
            wdata_v[i] = '0;
            rep[i]     = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                req_v     = '0;
                reissue_v = '0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (req_v[i] && ack_v[i]) begin
                        req_v[i] = 1'b0;
                        if (rep[i] != 0) begin
                            rep[i]--;
                            reissue_v[i] = 1'b1;
                        end
                    end else if (reissue_v[i]) begin
                        reissue_v[i] = 1'b0;
                        addr_v[i]    = addr_v[i] + 1'b1;
                        wdata_v[i]   = wdata_v[i] + 1'b1;
                        raise(i);
                    end
                end
                while (cmd_q.size() > 0 && !req_v[cmd_q[0].id] && !reissue_v[cmd_q[0].id]) begin
                    c = cmd_q.pop_front();
                    we_v[c.id]    = c.we;
                    addr_v[c.id]  = c.addr;
                    wdata_v[c.id] = c.wdata;
                    rep[c.id]     = c.rep;
                    raise(int'(c.id));
                end
            end
        end
    end

    // ---------------- memory model ----------------
    initial begin : memory
        int   cnt;
        acc_t first;
        cnt           = 0;
        first         = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (stray_ack) begin
                stray_ack     = 1'b0;
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 16'hDEAD;
                cnt           = 0;
            end else if (mem_auto && bus.mem_req && !reset) begin
                if (cnt == 0) begin
                    first = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
                end else begin
                    check("mem_hold", 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'(first));
                end
                cnt++;
                if (cnt >= mem_lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_fn(bus.mem_addr);
                    mem_log_q.push_back(first);
                    last_mem_ack_cyc = cyc;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    initial begin : monitor
        int   id;
        int   idx;
        exp_t e;
        acc_t a;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (int'(dbg_starve_cnt) > max_starve) max_starve = int'(dbg_starve_cnt);
                if (ack_v != 0) begin
                    check("ack_onehot", 64'($countones(ack_v)), 64'd1);
                    check("ack_memreq_low", 64'(bus.mem_req), 64'd0);
                    id = ack_v[0] ? 0 : (ack_v[1] ? 1 : 2);
                    ack_id_q.push_back(id);
                    ack_cyc_q.push_back(cyc);
                    if (id == 2) starve_at_ldr = int'(dbg_starve_cnt);
                    idx = -1;
                    for (int k = 0; k < exp_q.size(); k++) begin
                        e = exp_t'(exp_q[k]);
                        if (idx < 0 && int'(e.id) == id) idx = k;
                    end
                    if (idx < 0) begin
                        check("ack_expected", 64'(id + 1), 64'd0);
                    end else begin
                        e = exp_t'(exp_q[idx]);
                        exp_q.delete(idx);
                        check("ack_rdata", 64'(bus.rdata), 64'(e.rdata));
                        last_rdata = e.rdata;
                        if (mem_log_q.size() == 0) begin
                            check("mem_access_seen", 64'd0, 64'd1);
                        end else begin
                            a = mem_log_q.pop_front();
                            check("mem_access", 64'(a), 64'({e.we, e.addr, e.wdata}));
                        end
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin : main
        int            ldr_idx;
        logic [2:0]    seen;
        int            rid;
        logic [AW-1:0] raddr;

        repeat (3) @(negedge clk);
        check("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_rdata", 64'(bus.rdata), 64'd0);
        check("rst_acks", 64'(ack_v), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_starve", 64'(dbg_starve_cnt), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // single CPU read, 2-cycle memory
        mem_lat = 2;
        clear_logs();
        push_cmd(1, 1'b0, 24'h004000, 16'h0000, 0);
        @(negedge clk);
        check("t1_c0_mem_req", 64'(bus.mem_req), 64'd0);
        @(negedge clk);
        check("t1_c1_mem_req", 64'(bus.mem_req), 64'd1);
        check("t1_c1_mem_addr", 64'(bus.mem_addr), 64'h004000);
        check("t1_c1_mem_we", 64'(bus.mem_we), 64'd0);
        @(negedge clk);
        check("t1_c2_mem_req", 64'(bus.mem_req), 64'd1);
        @(negedge clk);
        check("t1_c3_acks", 64'(ack_v), 64'b010);
        check("t1_c3_rdata", 64'(bus.rdata), 64'hBEEF);
        check("t1_c3_mem_req", 64'(bus.mem_req), 64'd0);
        @(negedge clk);
        check("t1_c4_state", 64'(dbg_state), 64'd0);
        check("t1_c4_acks", 64'(ack_v), 64'd0);
        drain(20);

        // simultaneous requests, 1-cycle memory
        mem_lat = 1;
        clear_logs();
        push_cmd(0, 1'b0, 24'h000100, 16'h0000, 0);
        push_cmd(1, 1'b0, 24'h004004, 16'h0000, 0);
        push_cmd(2, 1'b0, 24'h100000, 16'h0000, 0);
        drain(40);
        check("prio_count", 64'(ack_id_q.size()), 64'd3);
        if (ack_id_q.size() >= 3) begin
            for (int i = 0; i < 3; i++) check("prio_order", 64'(ack_id_q[i]), 64'(i));
            for (int i = 1; i < 3; i++) check("prio_spacing", 64'(ack_cyc_q[i] - ack_cyc_q[i-1]), 64'd3);
        end

        // loader starvation guard
        clear_logs();
        max_starve    = 0;
        starve_at_ldr = -1;
        push_cmd(2, 1'b0, 24'h100010, 16'h0000, 0);
        push_cmd(0, 1'b0, 24'h000300, 16'h0000, 11);
        push_cmd(1, 1'b0, 24'h004010, 16'h0000, 2);
        drain(300);
        ldr_idx = -1;
        for (int i = 0; i < ack_id_q.size(); i++) begin
            if (ldr_idx < 0 && ack_id_q[i] == 2) ldr_idx = i;
        end
        check("starve_grants_before_ldr", 64'(ldr_idx), 64'd8);
        check("starve_total", 64'(ack_id_q.size()), 64'd16);
        check("starve_max", 64'(max_starve), 64'(LIM));
        check("starve_at_ldr_ack", 64'(starve_at_ldr), 64'd0);
        check("starve_final", 64'(dbg_starve_cnt), 64'd0);

        // loader write, 3-cycle memory
        mem_lat = 3;
        clear_logs();
        push_cmd(2, 1'b1, 24'h1FFFFF, 16'h55AA, 0);
        @(negedge clk);
        @(negedge clk);
        check("wr_mem_req", 64'(bus.mem_req), 64'd1);
        check("wr_mem_we", 64'(bus.mem_we), 64'd1);
        check("wr_mem_addr", 64'(bus.mem_addr), 64'h1FFFFF);
        check("wr_mem_wdata", 64'(bus.mem_wdata), 64'h55AA);
        drain(30);
        check("wr_ack_count", 64'(ack_id_q.size()), 64'd1);
        if (ack_id_q.size() >= 1) begin
            check("wr_ack_id", 64'(ack_id_q[0]), 64'd2);
            check("wr_ack_latency", 64'(ack_cyc_q[0] - last_mem_ack_cyc), 64'd1);
        end

        // reset while BUSY, then a stray mem_ack just after release
        mem_auto = 1'b0;
        clear_logs();
        push_cmd(1, 1'b0, 24'h004020, 16'h0000, 0);
        @(negedge clk);
        @(negedge clk);
        check("rb_pre_mem_req", 64'(bus.mem_req), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rb_mem_req", 64'(bus.mem_req), 64'd0);
        check("rb_mem_we", 64'(bus.mem_we), 64'd0);
        check("rb_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rb_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rb_rdata", 64'(bus.rdata), 64'd0);
        check("rb_acks", 64'(ack_v), 64'd0);
        check("rb_state", 64'(dbg_state), 64'd0);
        exp_q.delete();
        reset     = 1'b0;
        stray_ack = 1'b1;
        seen      = '0;
        repeat (4) begin
            @(negedge clk);
            seen |= ack_v;
        end
        check("rb_no_ack", 64'(seen), 64'd0);
        check("rb_idle", 64'(dbg_state), 64'd0);
        check("rb_rdata_after", 64'(bus.rdata), 64'd0);
        mem_auto = 1'b1;
        mem_lat  = 1;
        push_cmd(0, 1'b0, 24'h000400, 16'h0000, 0);
        drain(20);
        check("rb_next_count", 64'(ack_id_q.size()), 64'd1);
        if (ack_id_q.size() >= 1) check("rb_next_id", 64'(ack_id_q[0]), 64'd0);

        // stray mem_ack while idle
        clear_logs();
        stray_ack = 1'b1;
        seen      = '0;
        repeat (3) begin
            @(negedge clk);
            seen |= ack_v;
        end
        check("stray_no_ack", 64'(seen), 64'd0);
        check("stray_rdata", 64'(bus.rdata), 64'(last_rdata));
        check("stray_state", 64'(dbg_state), 64'd0);

        // randomized single accesses
        for (int k = 0; k < 12; k++) begin
            mem_lat = int'($urandom_range(1, 4));
            rid     = int'($urandom_range(0, 2));
            raddr   = AW'($urandom_range(0, 32'hFFFFFF));
            push_cmd(rid, 1'($urandom_range(0, 1)), raddr, DW'($urandom_range(0, 16'hFFFF)), 0);
            drain(40);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
